// File: rtl/board_io_pkg.sv
// Shared definitions for the board I/O blocks: register map of the button
// input slave port and the default debounce interval.
package board_io_pkg;

    // Register addresses on the single-bit address bus.
    localparam logic ADDR_STATE   = 1'b0;  // debounced levels, read-only
    localparam logic ADDR_PENDING = 1'b1;  // sticky press flags, write-1-to-clear

    // 1 ms of settling time at a 100 MHz system clock.
    localparam int unsigned DEBOUNCE_CYCLES_100MHZ = 32'd100000;

endpackage : board_io_pkg

// File: rtl/debounce_chan.sv
// One input channel: two-flop synchronizer, debounce counter, stable level
// and registered press/release pulses that coincide with the level change.
module debounce_chan #(
    parameter int unsigned DEBOUNCE_CYCLES = 32'd4
) (
    input  logic clk,
    input  logic rst,
    input  logic pin_i,
    output logic state_o,
    output logic press_o,
    output logic release_o
);

    localparam int unsigned CTR_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CTR_W-1:0] CTR_MAX  = CTR_W'(DEBOUNCE_CYCLES - 32'd1);
    localparam logic [CTR_W-1:0] CTR_ONE  = CTR_W'(32'd1);
    localparam logic [CTR_W-1:0] CTR_ZERO = {CTR_W{1'b0}};

    if (DEBOUNCE_CYCLES < 32'd2) begin : g_bad_debounce
        $error("debounce_chan: DEBOUNCE_CYCLES must be at least 2");
    end

    logic             sync1_q;
    logic             sync2_q;
    logic [CTR_W-1:0] ctr_q;
    logic [CTR_W-1:0] ctr_d;
    logic             state_q;
    logic             state_d;
    logic             press_q;
    logic             press_d;
    logic             release_q;
    logic             release_d;

    // Count consecutive cycles the synchronized pin disagrees with the stable
    // level; flip the level (and pulse) once the count reaches its maximum.
    // The counter is cleared on agreement so it never wraps.
    always_comb begin
        ctr_d     = ctr_q;
        state_d   = state_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (sync2_q == state_q) begin
            ctr_d = CTR_ZERO;
        end else if (ctr_q == CTR_MAX) begin
            ctr_d     = CTR_ZERO;
            state_d   = sync2_q;
            press_d   = sync2_q;
            release_d = ~sync2_q;
        end else begin
            ctr_d = ctr_q + CTR_ONE;
        end
    end

    // Synchronizer chain and debounce state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            ctr_q     <= CTR_ZERO;
            state_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync1_q   <= pin_i;
            sync2_q   <= sync1_q;
            ctr_q     <= ctr_d;
            state_q   <= state_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign state_o   = state_q;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule : debounce_chan

// File: rtl/button_input_debounce.sv
// Debounced pushbutton/switch inputs with sticky press flags, an interrupt
// line and a single-cycle memory-mapped slave port for the SoC.
module button_input_debounce
    import board_io_pkg::*;
#(
    parameter int unsigned N_IN            = 32'd4,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_100MHZ
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_IN-1:0] pin_i,
    output logic [N_IN-1:0] state_o,
    output logic [N_IN-1:0] press_o,
    output logic [N_IN-1:0] release_o,
    output logic            irq_o,
    input  logic            bus_sel,
    input  logic            bus_we,
    input  logic            bus_addr,
    input  logic [N_IN-1:0] bus_wdata,
    output logic [N_IN-1:0] bus_rdata,
    output logic            bus_ack
);

    localparam logic [N_IN-1:0] ZERO_N = {N_IN{1'b0}};

    if ((N_IN < 32'd1) || (N_IN > 32'd32)) begin : g_bad_n_in
        $error("button_input_debounce: N_IN must be in 1..32");
    end
    if (DEBOUNCE_CYCLES < 32'd2) begin : g_bad_debounce
        $error("button_input_debounce: DEBOUNCE_CYCLES must be at least 2");
    end

    logic [N_IN-1:0] state_s;
    logic [N_IN-1:0] press_s;
    logic [N_IN-1:0] release_s;
    logic [N_IN-1:0] clear_s;
    logic [N_IN-1:0] pending_q;
    logic [N_IN-1:0] pending_d;
    logic            irq_q;
    logic            irq_d;
    logic            ack_q;
    logic            ack_d;
    logic [N_IN-1:0] rdata_q;
    logic [N_IN-1:0] rdata_d;

    for (genvar g = 0; g < N_IN; g++) begin : g_chan
        debounce_chan #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .pin_i    (pin_i[g]),
            .state_o  (state_s[g]),
            .press_o  (press_s[g]),
            .release_o(release_s[g])
        );
    end

    // Bus decode, sticky pending update (a press beats a same-cycle clear)
    // and read-data selection. An access is accepted only when no ack is
    // outstanding, so a held bus_sel is served every other cycle.
    always_comb begin
        clear_s = ZERO_N;
        ack_d   = bus_sel & ~ack_q;
        if (ack_d && bus_we && (bus_addr == ADDR_PENDING)) begin
            clear_s = bus_wdata;
        end else begin
            clear_s = ZERO_N;
        end

        pending_d = (pending_q & ~clear_s) | press_s;
        irq_d     = |pending_d;

        rdata_d = ZERO_N;
        if (ack_d && !bus_we) begin
            case (bus_addr)
                ADDR_STATE:   rdata_d = state_s;
                ADDR_PENDING: rdata_d = pending_q;
                default:      rdata_d = ZERO_N;
            endcase
        end else begin
            rdata_d = ZERO_N;
        end
    end

    // Pending flags, interrupt and bus response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= ZERO_N;
            irq_q     <= 1'b0;
            ack_q     <= 1'b0;
            rdata_q   <= ZERO_N;
        end else begin
            pending_q <= pending_d;
            irq_q     <= irq_d;
            ack_q     <= ack_d;
            rdata_q   <= rdata_d;
        end
    end

    assign state_o   = state_s;
    assign press_o   = press_s;
    assign release_o = release_s;
    assign irq_o     = irq_q;
    assign bus_ack   = ack_q;
    assign bus_rdata = rdata_q;

endmodule : button_input_debounce

// File: tb/tb_button_input_debounce.sv
// Directed bench for button_input_debounce with N_IN=4, DEBOUNCE_CYCLES=4.
module tb_button_input_debounce;

    localparam int unsigned N  = 32'd4;
    localparam int unsigned DC = 32'd4;

    logic         clk;
    logic         rst;
    logic [N-1:0] pin_i;
    logic [N-1:0] state_o;
    logic [N-1:0] press_o;
    logic [N-1:0] release_o;
    logic         irq_o;
    logic         bus_sel;
    logic         bus_we;
    logic         bus_addr;
    logic [N-1:0] bus_wdata;
    logic [N-1:0] bus_rdata;
    logic         bus_ack;

    int vectors = 0;
    int miscompares = 0;

    button_input_debounce #(
        .N_IN(N),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .pin_i    (pin_i),
        .state_o  (state_o),
        .press_o  (press_o),
        .release_o(release_o),
        .irq_o    (irq_o),
        .bus_sel  (bus_sel),
        .bus_we   (bus_we),
        .bus_addr (bus_addr),
        .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata),
        .bus_ack  (bus_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; pin_i = 4'b0000;
        bus_sel = 1'b0; bus_we = 1'b0; bus_addr = 1'b0; bus_wdata = 4'b0000;
        tick(); tick();
        vectors++; if (state_o !== 4'b0000) begin miscompares++; $display("FAIL reset_state: got %b exp 0000", state_o); end
        vectors++; if (press_o !== 4'b0000) begin miscompares++; $display("FAIL reset_press: got %b exp 0000", press_o); end
        vectors++; if (release_o !== 4'b0000) begin miscompares++; $display("FAIL reset_release: got %b exp 0000", release_o); end
        vectors++; if (irq_o !== 1'b0) begin miscompares++; $display("FAIL reset_irq: got %b exp 0", irq_o); end
        vectors++; if (bus_ack !== 1'b0) begin miscompares++; $display("FAIL reset_ack: got %b exp 0", bus_ack); end
        vectors++; if (bus_rdata !== 4'b0000) begin miscompares++; $display("FAIL reset_rdata: got %b exp 0000", bus_rdata); end
        rst = 1'b0;
    endtask

    task automatic test_clean_press();
        pin_i = 4'b0001;
        for (int k = 1; k <= 5; k++) begin
            tick();
            vectors++; if (state_o !== 4'b0000 || press_o !== 4'b0000) begin miscompares++; $display("FAIL press_wait%0d: state %b press %b exp 0000 0000", k, state_o, press_o); end
        end
        tick();
        vectors++; if (state_o !== 4'b0001) begin miscompares++; $display("FAIL press_state: got %b exp 0001", state_o); end
        vectors++; if (press_o !== 4'b0001) begin miscompares++; $display("FAIL press_pulse: got %b exp 0001", press_o); end
        vectors++; if (irq_o !== 1'b0) begin miscompares++; $display("FAIL press_irq_early: got %b exp 0", irq_o); end
        tick();
        vectors++; if (press_o !== 4'b0000) begin miscompares++; $display("FAIL press_pulse_end: got %b exp 0000", press_o); end
        vectors++; if (irq_o !== 1'b1) begin miscompares++; $display("FAIL press_irq: got %b exp 1", irq_o); end
    endtask

    task automatic test_glitch();
        pin_i = 4'b0011;
        tick(); tick(); tick();
        pin_i = 4'b0001;
        for (int k = 1; k <= 10; k++) begin
            tick();
            vectors++; if (state_o !== 4'b0001 || press_o !== 4'b0000) begin miscompares++; $display("FAIL glitch%0d: state %b press %b exp 0001 0000", k, state_o, press_o); end
        end
    endtask

    task automatic test_release();
        pin_i = 4'b0000;
        for (int k = 1; k <= 5; k++) begin
            tick();
            vectors++; if (state_o !== 4'b0001 || release_o !== 4'b0000) begin miscompares++; $display("FAIL release_wait%0d: state %b release %b exp 0001 0000", k, state_o, release_o); end
        end
        tick();
        vectors++; if (state_o !== 4'b0000) begin miscompares++; $display("FAIL release_state: got %b exp 0000", state_o); end
        vectors++; if (release_o !== 4'b0001) begin miscompares++; $display("FAIL release_pulse: got %b exp 0001", release_o); end
        vectors++; if (press_o !== 4'b0000) begin miscompares++; $display("FAIL release_nopress: got %b exp 0000", press_o); end
        tick();
        vectors++; if (release_o !== 4'b0000) begin miscompares++; $display("FAIL release_pulse_end: got %b exp 0000", release_o); end
        vectors++; if (irq_o !== 1'b1) begin miscompares++; $display("FAIL release_irq_kept: got %b exp 1", irq_o); end
    endtask

    task automatic test_bus();
        // read PENDING
        bus_sel = 1'b1; bus_we = 1'b0; bus_addr = 1'b1;
        tick();
        vectors++; if (bus_ack !== 1'b1) begin miscompares++; $display("FAIL rd_ack: got %b exp 1", bus_ack); end
        vectors++; if (bus_rdata !== 4'b0001) begin miscompares++; $display("FAIL rd_pending: got %b exp 0001", bus_rdata); end
        bus_sel = 1'b0;
        tick();
        vectors++; if (bus_ack !== 1'b0 || bus_rdata !== 4'b0000) begin miscompares++; $display("FAIL rd_idle: ack %b rdata %b exp 0 0000", bus_ack, bus_rdata); end
        // write to STATE is ignored but acknowledged
        bus_sel = 1'b1; bus_we = 1'b1; bus_addr = 1'b0; bus_wdata = 4'b1111;
        tick();
        vectors++; if (bus_ack !== 1'b1 || bus_rdata !== 4'b0000) begin miscompares++; $display("FAIL wr_state_ack: ack %b rdata %b exp 1 0000", bus_ack, bus_rdata); end
        bus_sel = 1'b0;
        tick();
        vectors++; if (irq_o !== 1'b1) begin miscompares++; $display("FAIL wr_state_ignored: irq %b exp 1", irq_o); end
        // held select: ack every other cycle
        bus_sel = 1'b1; bus_we = 1'b0; bus_addr = 1'b1;
        tick();
        vectors++; if (bus_ack !== 1'b1 || bus_rdata !== 4'b0001) begin miscompares++; $display("FAIL held1: ack %b rdata %b exp 1 0001", bus_ack, bus_rdata); end
        tick();
        vectors++; if (bus_ack !== 1'b0 || bus_rdata !== 4'b0000) begin miscompares++; $display("FAIL held2: ack %b rdata %b exp 0 0000", bus_ack, bus_rdata); end
        tick();
        vectors++; if (bus_ack !== 1'b1) begin miscompares++; $display("FAIL held3: ack %b exp 1", bus_ack); end
        bus_sel = 1'b0;
        tick();
        // W1C of bit 0
        bus_sel = 1'b1; bus_we = 1'b1; bus_addr = 1'b1; bus_wdata = 4'b0001;
        tick();
        vectors++; if (bus_ack !== 1'b1) begin miscompares++; $display("FAIL w1c_ack: got %b exp 1", bus_ack); end
        vectors++; if (irq_o !== 1'b0) begin miscompares++; $display("FAIL w1c_irq: got %b exp 0", irq_o); end
        bus_sel = 1'b0; bus_we = 1'b0; bus_wdata = 4'b0000;
        tick();
        bus_sel = 1'b1;
        tick();
        vectors++; if (bus_rdata !== 4'b0000) begin miscompares++; $display("FAIL w1c_readback: got %b exp 0000", bus_rdata); end
        bus_sel = 1'b0;
        tick();
    endtask

    task automatic test_collision();
        pin_i = 4'b0100;
        for (int k = 1; k <= 5; k++) tick();
        tick();
        vectors++; if (press_o !== 4'b0100) begin miscompares++; $display("FAIL coll_press: got %b exp 0100", press_o); end
        bus_sel = 1'b1; bus_we = 1'b1; bus_addr = 1'b1; bus_wdata = 4'b0100;
        tick();
        vectors++; if (bus_ack !== 1'b1 || irq_o !== 1'b1) begin miscompares++; $display("FAIL coll_irq: ack %b irq %b exp 1 1", bus_ack, irq_o); end
        bus_sel = 1'b0; bus_we = 1'b0; bus_wdata = 4'b0000;
        tick();
        bus_sel = 1'b1; bus_addr = 1'b1;
        tick();
        vectors++; if (bus_rdata !== 4'b0100) begin miscompares++; $display("FAIL coll_pending: got %b exp 0100", bus_rdata); end
        bus_sel = 1'b0;
        tick();
        bus_sel = 1'b1; bus_addr = 1'b0;
        tick();
        vectors++; if (bus_rdata !== 4'b0100) begin miscompares++; $display("FAIL rd_state: got %b exp 0100", bus_rdata); end
        bus_sel = 1'b0;
        tick();
    endtask

    task automatic test_read_race();
        pin_i = 4'b0110;
        for (int k = 1; k <= 5; k++) tick();
        tick();
        vectors++; if (press_o !== 4'b0010) begin miscompares++; $display("FAIL race_press: got %b exp 0010", press_o); end
        bus_sel = 1'b1; bus_we = 1'b0; bus_addr = 1'b1;
        tick();
        vectors++; if (bus_rdata !== 4'b0100) begin miscompares++; $display("FAIL race_preset: got %b exp 0100", bus_rdata); end
        bus_sel = 1'b0;
        tick();
        bus_sel = 1'b1;
        tick();
        vectors++; if (bus_rdata !== 4'b0110) begin miscompares++; $display("FAIL race_after: got %b exp 0110", bus_rdata); end
        bus_sel = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        pin_i = 4'b1000;
        tick(); tick(); tick(); tick();
        rst = 1'b1;
        tick();
        vectors++; if (state_o !== 4'b0000 || press_o !== 4'b0000 || irq_o !== 1'b0) begin miscompares++; $display("FAIL midrst_clear: state %b press %b irq %b exp 0000 0000 0", state_o, press_o, irq_o); end
        rst = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            vectors++; if (state_o !== 4'b0000) begin miscompares++; $display("FAIL midrst_wait%0d: got %b exp 0000", k, state_o); end
        end
        tick();
        vectors++; if (state_o !== 4'b1000 || press_o !== 4'b1000) begin miscompares++; $display("FAIL midrst_press: state %b press %b exp 1000 1000", state_o, press_o); end
        tick();
        vectors++; if (press_o !== 4'b0000 || irq_o !== 1'b1) begin miscompares++; $display("FAIL midrst_irq: press %b irq %b exp 0000 1", press_o, irq_o); end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_glitch();
        test_release();
        test_bus();
        test_collision();
        test_read_race();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_button_input_debounce
